// File: rtl/branch_predict_unit.sv
// Branch predictor: direct-mapped BTB with 2-bit saturating counters and performance counters.
// Optional gshare counter indexing is enabled by defining BPU_GSHARE_EN.
module branch_predict_unit #(
  parameter int unsigned XLEN    = 32,
  parameter int unsigned ENTRIES = 64,
  parameter int unsigned CNT_W   = 32
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [XLEN-1:0]            lookup_pc,
  output logic                       pred_hit,
  output logic                       pred_taken,
  output logic [XLEN-1:0]            pred_target,
  output logic [1:0]                 pred_state,
`ifdef BPU_GSHARE_EN
  output logic [$clog2(ENTRIES)-1:0] pred_ghr,
  input  logic [$clog2(ENTRIES)-1:0] upd_ghr,
`endif
  input  logic                       stall,
  input  logic                       upd_valid,
  input  logic                       upd_is_branch,
  input  logic                       upd_is_jump,
  input  logic                       upd_taken,
  input  logic                       upd_mispredict,
  input  logic [XLEN-1:0]            upd_pc,
  input  logic [XLEN-1:0]            upd_target,
  output logic [CNT_W-1:0]           br_cnt,
  output logic [CNT_W-1:0]           mispred_cnt
);

  localparam int unsigned IdxW = $clog2(ENTRIES);
  localparam int unsigned TagW = XLEN - IdxW - 2;

  logic [ENTRIES-1:0] valid_q;
  logic [ENTRIES-1:0] jump_q;
  logic [1:0]         cnt_q [ENTRIES];
  logic [TagW-1:0]    tag_q [ENTRIES];
  logic [XLEN-1:0]    tgt_q [ENTRIES];
  logic [CNT_W-1:0]   br_cnt_q, br_cnt_d;
  logic [CNT_W-1:0]   mis_cnt_q, mis_cnt_d;

  logic [IdxW-1:0] l_idx, l_cidx, u_idx, u_cidx;
  logic [TagW-1:0] l_tag, u_tag;
  logic            u_hit, upd_acc, btb_we;
  logic [1:0]      u_cnt, cnt_new;
  logic            unused_pc_lsbs;

  assign unused_pc_lsbs = ^{lookup_pc[1:0], upd_pc[1:0]};

  assign l_idx = lookup_pc[IdxW+1:2];
  assign l_tag = lookup_pc[XLEN-1:IdxW+2];
  assign u_idx = upd_pc[IdxW+1:2];
  assign u_tag = upd_pc[XLEN-1:IdxW+2];

`ifdef BPU_GSHARE_EN
  logic [IdxW-1:0] ghr_q, ghr_d;

  assign l_cidx   = l_idx ^ ghr_q;
  assign u_cidx   = u_idx ^ upd_ghr;
  assign pred_ghr = ghr_q;

  // A mispredict restarts history from the snapshot carried with the resolving branch.
  always_comb begin
    ghr_d = ghr_q;
    if (upd_acc && !upd_is_jump) begin
      ghr_d = upd_mispredict ? {upd_ghr[IdxW-2:0], upd_taken} : {ghr_q[IdxW-2:0], upd_taken};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ghr_q <= '0;
    end else begin
      ghr_q <= ghr_d;
    end
  end
`else
  assign l_cidx = l_idx;
  assign u_cidx = u_idx;
`endif

  always_comb begin
    pred_hit    = valid_q[l_idx] && (tag_q[l_idx] == l_tag);
    pred_taken  = pred_hit && (jump_q[l_idx] || cnt_q[l_cidx][1]);
    pred_target = pred_taken ? tgt_q[l_idx] : lookup_pc + XLEN'(4);
    pred_state  = cnt_q[l_cidx];
  end

  assign upd_acc = upd_valid && !stall && (upd_is_branch || upd_is_jump);
  assign u_hit   = valid_q[u_idx] && (tag_q[u_idx] == u_tag);
  assign btb_we  = upd_acc && (upd_is_jump || upd_taken);
  assign u_cnt   = cnt_q[u_cidx];

  always_comb begin
    cnt_new = u_cnt;
    if (upd_is_jump) begin
      cnt_new = 2'b11;
    end else if (upd_taken && !u_hit) begin
      cnt_new = 2'b10;
    end else if (upd_taken) begin
      cnt_new = (u_cnt == 2'b11) ? u_cnt : u_cnt + 2'b01;
    end else begin
      cnt_new = (u_cnt == 2'b00) ? u_cnt : u_cnt - 2'b01;
    end
  end

  always_comb begin
    br_cnt_d  = br_cnt_q;
    mis_cnt_d = mis_cnt_q;
    if (upd_acc) begin
      if (!(&br_cnt_q)) br_cnt_d = br_cnt_q + CNT_W'(1);
      if (upd_mispredict && !(&mis_cnt_q)) mis_cnt_d = mis_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q   <= '0;
      jump_q    <= '0;
      br_cnt_q  <= '0;
      mis_cnt_q <= '0;
      for (int i = 0; i < ENTRIES; i++) cnt_q[i] <= 2'b01;
    end else begin
      br_cnt_q  <= br_cnt_d;
      mis_cnt_q <= mis_cnt_d;
      if (upd_acc) begin
        cnt_q[u_cidx] <= cnt_new;
        if (btb_we) valid_q[u_idx] <= 1'b1;
        if (upd_is_jump) begin
          jump_q[u_idx] <= 1'b1;
        end else if (upd_taken || u_hit) begin
          jump_q[u_idx] <= 1'b0;
        end
      end
    end
  end

  // Tag/target payload carries no reset; valid_q guards every use.
  always_ff @(posedge clk) begin
    if (btb_we) begin
      tag_q[u_idx] <= u_tag;
      tgt_q[u_idx] <= upd_target;
    end
  end

  assign br_cnt      = br_cnt_q;
  assign mispred_cnt = mis_cnt_q;

endmodule

// File: tb/tb_branch_predict_unit.sv
// Scoreboard bench for branch_predict_unit: stimulus queues expectations, a negedge monitor checks.
module tb_branch_predict_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] lookup_pc = 32'h100;
  logic        pred_hit, pred_taken;
  logic [31:0] pred_target;
  logic [1:0]  pred_state;
  logic        stall = 1'b0;
  logic        upd_valid = 1'b0, upd_is_branch = 1'b0, upd_is_jump = 1'b0;
  logic        upd_taken = 1'b0, upd_mispredict = 1'b0;
  logic [31:0] upd_pc = '0, upd_target = '0;
  logic [31:0] br_cnt, mispred_cnt;
`ifdef BPU_GSHARE_EN
  logic [5:0]  pred_ghr;
  logic [5:0]  upd_ghr = '0;
`endif

  branch_predict_unit #(.XLEN(32), .ENTRIES(64), .CNT_W(32)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .lookup_pc     (lookup_pc),
    .pred_hit      (pred_hit),
    .pred_taken    (pred_taken),
    .pred_target   (pred_target),
    .pred_state    (pred_state),
`ifdef BPU_GSHARE_EN
    .pred_ghr      (pred_ghr),
    .upd_ghr       (upd_ghr),
`endif
    .stall         (stall),
    .upd_valid     (upd_valid),
    .upd_is_branch (upd_is_branch),
    .upd_is_jump   (upd_is_jump),
    .upd_taken     (upd_taken),
    .upd_mispredict(upd_mispredict),
    .upd_pc        (upd_pc),
    .upd_target    (upd_target),
    .br_cnt        (br_cnt),
    .mispred_cnt   (mispred_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        hit;
    logic        taken;
    logic [31:0] tgt;
    logic [1:0]  st;
    logic [31:0] br;
    logic [31:0] mis;
    logic [5:0]  ghr;
  } exp_t;

  exp_t        sb_q[$];
  exp_t        mon_e;
  int          n_pass = 0;
  int          n_tot = 0;
  int          n_vec = 0;
  logic [31:0] exp_br = 0, exp_mis = 0;
  logic [5:0]  exp_ghr = 0, ughr = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_tot++;
    if (act === req) n_pass++;
    else $display("FAIL vec%0d %s: got 0x%0h expected 0x%0h", n_vec, name, act, req);
  endtask

  always @(negedge clk) begin
    if (sb_q.size() > 0) begin
      mon_e = sb_q.pop_front();
      n_vec++;
      chk("pred_hit", 32'(pred_hit), 32'(mon_e.hit));
      chk("pred_taken", 32'(pred_taken), 32'(mon_e.taken));
      chk("pred_target", pred_target, mon_e.tgt);
      chk("pred_state", 32'(pred_state), 32'(mon_e.st));
      chk("br_cnt", br_cnt, mon_e.br);
      chk("mispred_cnt", mispred_cnt, mon_e.mis);
`ifdef BPU_GSHARE_EN
      chk("pred_ghr", 32'(pred_ghr), 32'(mon_e.ghr));
`endif
    end
  end

  // One cycle: drive update + lookup after the edge, queue the lookup expectation for this cycle.
  task automatic cyc(input logic uv, input logic ub, input logic uj, input logic ut,
                     input logic um, input logic st, input logic [31:0] upc,
                     input logic [31:0] utgt, input logic [31:0] lpc, input logic ehit,
                     input logic etk, input logic [31:0] etgt, input logic [1:0] est);
    exp_t e;
    @(posedge clk);
    #1;
    upd_valid = uv; upd_is_branch = ub; upd_is_jump = uj; upd_taken = ut;
    upd_mispredict = um; stall = st; upd_pc = upd_pc; upd_pc = upc; upd_target = utgt;
    lookup_pc = lpc;
`ifdef BPU_GSHARE_EN
    upd_ghr = ughr;
`endif
    e = '{ehit, etk, etgt, est, exp_br, exp_mis, exp_ghr};
    sb_q.push_back(e);
    if (rst_n && uv && !st && (ub || uj)) begin
      exp_br++;
      if (um) exp_mis++;
    end
  endtask

  task automatic idle_look(input logic [31:0] lpc, input logic ehit, input logic etk,
                           input logic [31:0] etgt, input logic [1:0] est);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, lpc, ehit, etk, etgt, est);
  endtask

  task automatic mid_reset(input logic [31:0] lpc);
    exp_t e;
    @(posedge clk);
    #1;
    upd_valid = 1'b0;
    rst_n = 1'b0;
    lookup_pc = lpc;
    exp_br = 0; exp_mis = 0; exp_ghr = 0;
    e = '{1'b0, 1'b0, lpc + 32'd4, 2'b01, 32'd0, 32'd0, 6'd0};
    sb_q.push_back(e);
    @(negedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    // Update presented during reset must be discarded.
    cyc(1, 1, 0, 1, 0, 0, 32'h200, 32'h180, 32'h100, 0, 0, 32'h104, 2'b01);
    @(negedge clk);
    #1;
    rst_n = 1'b1;
    upd_valid = 1'b0;
`ifdef BPU_GSHARE_EN
    ughr = 0; exp_ghr = 0;
    cyc(1, 1, 0, 1, 0, 0, 32'h200, 32'h180, 32'h200, 0, 0, 32'h204, 2'b01);
    ughr = 1; exp_ghr = 1;
    cyc(1, 1, 0, 1, 0, 0, 32'h200, 32'h180, 32'h200, 1, 0, 32'h204, 2'b01);
    ughr = 3; exp_ghr = 3;
    cyc(1, 1, 0, 0, 1, 0, 32'h200, 32'h0, 32'h200, 1, 0, 32'h204, 2'b01);
    exp_ghr = 6;
    idle_look(32'h200, 1, 0, 32'h204, 2'b01);
    idle_look(32'h214, 0, 0, 32'h218, 2'b00);
    mid_reset(32'h200);
    idle_look(32'h214, 0, 0, 32'h218, 2'b01);
`else
    idle_look(32'h200, 0, 0, 32'h204, 2'b01);
    // Same-cycle lookup sees pre-update state.
    cyc(1, 1, 0, 1, 1, 0, 32'h200, 32'h180, 32'h200, 0, 0, 32'h204, 2'b01);
    idle_look(32'h200, 1, 1, 32'h180, 2'b10);
    cyc(1, 1, 0, 0, 1, 0, 32'h200, 32'h0, 32'h200, 1, 1, 32'h180, 2'b10);
    cyc(1, 1, 0, 0, 0, 0, 32'h200, 32'h0, 32'h200, 1, 0, 32'h204, 2'b01);
    cyc(1, 1, 0, 0, 0, 0, 32'h200, 32'h0, 32'h200, 1, 0, 32'h204, 2'b00);
    idle_look(32'h200, 1, 0, 32'h204, 2'b00);
    // Ignored updates: stalled, neither kind, not valid.
    cyc(1, 0, 1, 1, 0, 1, 32'h200, 32'h999, 32'h200, 1, 0, 32'h204, 2'b00);
    cyc(1, 0, 0, 1, 1, 0, 32'h200, 32'h999, 32'h200, 1, 0, 32'h204, 2'b00);
    cyc(0, 1, 0, 1, 1, 0, 32'h200, 32'h999, 32'h200, 1, 0, 32'h204, 2'b00);
    idle_look(32'h200, 1, 0, 32'h204, 2'b00);
    // Jump at 0x300, then aliasing branch at 0x400 steals the entry.
    cyc(1, 0, 1, 1, 0, 0, 32'h300, 32'h400, 32'h200, 1, 0, 32'h204, 2'b00);
    idle_look(32'h300, 1, 1, 32'h400, 2'b11);
    idle_look(32'h200, 0, 0, 32'h204, 2'b11);
    cyc(1, 1, 0, 1, 0, 0, 32'h400, 32'h500, 32'h300, 1, 1, 32'h400, 2'b11);
    idle_look(32'h300, 0, 0, 32'h304, 2'b10);
    idle_look(32'h400, 1, 1, 32'h500, 2'b10);
    // Hit-taken increments, rewrites target, saturates at 11; then decrements.
    cyc(1, 1, 0, 1, 0, 0, 32'h400, 32'h540, 32'h400, 1, 1, 32'h500, 2'b10);
    cyc(1, 1, 0, 1, 0, 0, 32'h400, 32'h540, 32'h400, 1, 1, 32'h540, 2'b11);
    cyc(1, 1, 0, 0, 0, 0, 32'h400, 32'h0, 32'h400, 1, 1, 32'h540, 2'b11);
    cyc(1, 1, 0, 0, 0, 0, 32'h400, 32'h0, 32'h400, 1, 1, 32'h540, 2'b10);
    // Not-taken miss at index 1: counter drops, no allocation.
    cyc(1, 1, 0, 0, 0, 0, 32'h104, 32'h0, 32'h400, 1, 0, 32'h404, 2'b01);
    idle_look(32'h104, 0, 0, 32'h108, 2'b00);
    idle_look(32'hFFFF_FFFC, 0, 0, 32'h0, 2'b01);
    // Jump over a branch entry, then branch hits must clear the jump bit.
    cyc(1, 0, 1, 1, 0, 0, 32'h400, 32'h600, 32'h104, 0, 0, 32'h108, 2'b00);
    cyc(1, 1, 0, 0, 0, 0, 32'h400, 32'h0, 32'h400, 1, 1, 32'h600, 2'b11);
    cyc(1, 1, 0, 0, 0, 0, 32'h400, 32'h0, 32'h400, 1, 1, 32'h600, 2'b10);
    idle_look(32'h400, 1, 0, 32'h404, 2'b01);
    mid_reset(32'h400);
    idle_look(32'h104, 0, 0, 32'h108, 2'b01);
`endif
    for (int i = 0; i < 10 && sb_q.size() > 0; i++) @(posedge clk);
    if (sb_q.size() > 0) begin
      n_tot++;
      $display("FAIL drain: %0d expectations left, expected 0", sb_q.size());
    end
    @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule

// File: doc/branch_predict_unit.md
BRANCH_PREDICT_UNIT -- requirements
Module: branch_predict_unit

Interface
REQ-001 Parameter XLEN, 32, address/target width.
REQ-002 Parameter ENTRIES, 64, BTB and counter-table depth; power of two, >=4; IDX_W = log2(ENTRIES).
REQ-003 Parameter CNT_W, 32, width of each performance counter.
REQ-004 Port clk  in  1  rising-edge clock.
REQ-005 Port rst_n  in  1  asynchronous active-low reset.
REQ-006 Port lookup_pc  in  XLEN  fetch-stage PC.
REQ-007 Port pred_hit  out  1  BTB tag hit for lookup_pc.
REQ-008 Port pred_taken  out  1  predicted redirect.
REQ-009 Port pred_target  out  XLEN  next-fetch address.
REQ-010 Port pred_state  out  2  counter value used, carried down the pipe.
REQ-011 Port stall  in  1  pipeline stall; blocks updates.
REQ-012 Port upd_valid, upd_is_branch, upd_is_jump, upd_taken, upd_mispredict  in  1 each  execute-stage resolution.
REQ-013 Port upd_pc, upd_target  in  XLEN each  resolved instruction PC and taken target.
REQ-014 Port br_cnt, mispred_cnt  out  CNT_W each  performance counters.

Function
REQ-015 Index = pc[IDX_W+1:2]; tag = pc[XLEN-1:IDX_W+2]; per-entry state: valid, tag, target, jump bit, 2-bit counter.
REQ-016 Lookup SHALL be combinational, 0-cycle latency: pred_hit = valid & tag match at lookup index.
REQ-017 pred_taken = pred_hit & (jump bit | counter[1]); pred_target = pred_taken ? stored target : lookup_pc+4 (mod 2^XLEN).
REQ-018 pred_state = counter at counter index, regardless of pred_hit.
REQ-019 Accepted update = upd_valid & ~stall & (upd_is_branch | upd_is_jump); all other updates SHALL be ignored.
REQ-020 Accepted jump: write valid=1, tag, target, jump bit=1, counter=11.
REQ-021 Accepted branch, tag hit: counter saturating +1 if taken, -1 if not (11 and 00 hold); target rewritten when taken; jump bit=0.
REQ-022 Accepted branch, tag miss, taken: allocate (overwrite) entry, counter=10, jump bit=0.
REQ-023 Accepted branch, tag miss, not taken: no BTB allocation; counter entry still decremented.
REQ-024 Updates take effect at the clock edge; same-cycle lookup of the updated index SHALL return pre-update values (no bypass).
REQ-025 br_cnt +1 per accepted update; mispred_cnt +1 per accepted update with upd_mispredict; both saturate at all-ones.

Reset
REQ-026 On rst_n low, immediately: all valid=0, all counters=01, jump bits=0, br_cnt=0, mispred_cnt=0, history=0; tag/target arrays need not be reset.
REQ-027 Outputs during and after reset: pred_hit=0, pred_taken=0, pred_target=lookup_pc+4, pred_state=01.
REQ-028 An update coincident with reset SHALL be discarded.

Configuration
REQ-029 Macro BPU_GSHARE_EN.
REQ-030 Defined: IDX_W-bit global history register ghr; counter index = pc index XOR ghr; BTB still PC-indexed; extra ports pred_ghr out IDX_W and upd_ghr in IDX_W.
REQ-031 Defined: pred_ghr = ghr; update counter index = upd_pc index XOR upd_ghr; accepted branch shifts history: mispredicted -> ghr = {upd_ghr[IDX_W-2:0], upd_taken}, otherwise -> ghr = {ghr[IDX_W-2:0], upd_taken}; jumps leave ghr unchanged.
REQ-032 Undefined: counter index = PC index, no ghr, no pred_ghr/upd_ghr ports.

Verification
REQ-033 Reset, lookup_pc=0x100 -> pred_hit=0, pred_taken=0, pred_target=0x104, pred_state=01.
REQ-034 Taken branch upd_pc=0x200, upd_target=0x180, next cycle lookup 0x200 -> pred_hit=1, pred_taken=1, pred_target=0x180, pred_state=10.
REQ-035 Three not-taken updates at 0x200 after REQ-034 -> pred_state 01, 00, 00; pred_taken=0, pred_hit=1, pred_target=0x204.
REQ-036 Jump at 0x300 target 0x400, then branch 0x400 (aliases index, tag differs) taken target 0x500 -> lookup 0x300 miss, target 0x304; lookup 0x400 hits 0x500.
REQ-037 Update with stall=1 or upd_valid=1 with neither is_branch nor is_jump -> table and br_cnt unchanged; 5 accepted updates with 2 mispredicts -> br_cnt=5, mispred_cnt=2.
REQ-038 BPU_GSHARE_EN: taken, taken, then mispredicted not-taken with upd_ghr=0b000011 -> ghr=0b000110; rst_n low mid-sequence -> ghr=0, counters 01 immediately.
